pipe_chain_elastic: RTL and testbench

- Parametrised elastic pipeline chain: DEPTH register stages of WIDTH-bit payload with per-stage valid bits and valid/ready backpressure.
- Generalises the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers into one configurable block with:
  - bubble collapse (a stalled downstream stage does not freeze upstream empty slots),
  - selective per-stage flush (branch-taken kill),
  - global hold (hazard stall),
  - occupancy and flush-drop counters.
- Sits between instruction fetch and the consumer stage. It also serves as a drop-in for multi-cycle functional-unit pipelines.

---
 rtl/pipe_chain_elastic.sv | 89 ++++++++
 tb/tb_pipe_chain_elastic.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_chain_elastic.sv
// rtl/pipe_chain_elastic.sv - elastic DEPTH-stage payload pipeline with bubble collapse,
// per-stage flush, global hold, occupancy and saturating flush-drop counters.
module pipe_chain_elastic #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       hold,
  input  logic [DEPTH-1:0]           flush_mask,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           drop_count
);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int SUM_W = CNT_W + 5;
  localparam logic [SUM_W-1:0] DROP_MAX = {5'd0, {CNT_W{1'b1}}};

  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] mv, load, resident, killed;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [WIDTH-1:0] src    [DEPTH];
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [4:0]       kill_n;
  logic [SUM_W-1:0] drop_sum;
  logic             in_xfer;

  // A stage moves when the next one is empty or is itself moving, so a
  // stall at the output only blocks the contiguous run of full stages.
  always_comb begin
    mv = '0;
    mv[DEPTH-1] = v_q[DEPTH-1] & out_ready & ~hold;
    for (int i = DEPTH-2; i >= 0; i--) begin
      mv[i] = v_q[i] & ~hold & (~v_q[i+1] | mv[i+1]);
    end
  end

  assign in_ready   = ~hold & (~v_q[0] | mv[0]);
  assign in_xfer    = in_valid & in_ready;
  assign out_valid  = v_q[DEPTH-1] & ~hold;
  assign out_data   = data_q[DEPTH-1];
  assign occupancy  = occ_q;
  assign drop_count = drop_q;

  always_comb begin
    load    = '0;
    load[0] = in_xfer;
    src[0]  = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      load[i] = mv[i-1];
      src[i]  = data_q[i-1];
    end
    // resident = what each stage would hold after the edge absent any flush
    resident = load | (v_q & ~mv);
    killed   = resident & flush_mask;
    v_d      = resident & ~flush_mask;
    kill_n   = '0;
    occ_d    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill_n    = kill_n + 5'(killed[i]);
      occ_d     = occ_d + OCC_W'(v_d[i]);
      data_d[i] = (load[i] & ~flush_mask[i]) ? src[i] : data_q[i];
    end
    drop_sum = SUM_W'(drop_q) + SUM_W'(kill_n);
    drop_d   = (drop_sum > DROP_MAX) ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= '0;
      occ_q  <= '0;
      drop_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      v_q    <= v_d;
      occ_q  <= occ_d;
      drop_q <= drop_d;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= data_d[i];
    end
  end
endmodule

// File: tb/tb_pipe_chain_elastic.sv
// tb/tb_pipe_chain_elastic.sv - table-driven and scoreboard bench for pipe_chain_elastic
module tb_pipe_chain_elastic;
  localparam int W = 32;
  localparam int D = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, hold;
  logic [W-1:0] in_data, out_data;
  logic [D-1:0] flush_mask;
  logic [2:0]   occupancy;
  logic [15:0]  drop_count;

  logic         s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_hold;
  logic [W-1:0] s_in_data, s_out_data;
  logic [D-1:0] s_flush;
  logic [2:0]   s_occ;
  logic [1:0]   s_drop;

  pipe_chain_elastic #(.WIDTH(W), .DEPTH(D), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .hold(hold),
    .flush_mask(flush_mask), .occupancy(occupancy), .drop_count(drop_count)
  );

  pipe_chain_elastic #(.WIDTH(W), .DEPTH(D), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .hold(s_hold),
    .flush_mask(s_flush), .occupancy(s_occ), .drop_count(s_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         ir;
    logic         ov;
    logic [2:0]   occ;
  } vec_t;

  vec_t         tbl[$];
  logic [W-1:0] sb[$];
  int           n_checks = 0;
  int           n_fail = 0;

  function automatic vec_t mk(input logic iv, input logic [W-1:0] d, input logic ordy,
                              input logic ir, input logic ov, input logic [2:0] occ);
    vec_t r;
    r.iv = iv; r.d = d; r.ordy = ordy; r.ir = ir; r.ov = ov; r.occ = occ;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy,
                       input logic h, input logic [D-1:0] fm);
    in_valid = iv; in_data = d; out_ready = ordy; hold = h; flush_mask = fm;
    #1;
  endtask

  // Samples handshakes before the edge: output words are checked against the
  // scoreboard head, accepted (non-flushed) inputs are queued.
  task automatic tick();
    logic [W-1:0] exp;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out_unexpected: got %0h expected no output", out_data);
      end else begin
        exp = sb.pop_front();
        chk("out_data", out_data, exp);
      end
    end
    if (in_valid && in_ready && !flush_mask[0]) sb.push_back(in_data);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input string nm);
    int k = 0;
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    while ((out_valid || occupancy != 0) && k < 20) begin
      tick();
      drive(1'b0, '0, 1'b1, 1'b0, '0);
      k++;
    end
    chk({nm, "_drained"}, occupancy, 0);
    chk({nm, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    // streaming 0x1..0x8 with out_ready=1
    for (int r = 0; r < 8; r++) tbl.push_back(mk(1'b1, W'(r + 1), 1'b1, 1'b1, r >= 5, 3'(r < 5 ? r : 5)));
    tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, 1'b1, 3'd5));
    tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, 1'b1, 3'd4));
    tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, 1'b1, 3'd3));
    tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, 1'b1, 3'd2));
    tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, 1'b1, 3'd1));
    tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, 1'b0, 3'd0));
    // backpressure: park words in stages 4 and 1, then collapse and fill
    tbl.push_back(mk(1'b1, 32'hB0, 1'b0, 1'b1, 1'b0, 3'd0));
    tbl.push_back(mk(1'b0, '0,     1'b0, 1'b1, 1'b0, 3'd1));
    tbl.push_back(mk(1'b0, '0,     1'b0, 1'b1, 1'b0, 3'd1));
    tbl.push_back(mk(1'b1, 32'hB1, 1'b0, 1'b1, 1'b0, 3'd1));
    tbl.push_back(mk(1'b0, '0,     1'b0, 1'b1, 1'b0, 3'd2));
    tbl.push_back(mk(1'b0, '0,     1'b0, 1'b1, 1'b1, 3'd2));
    tbl.push_back(mk(1'b0, '0,     1'b0, 1'b1, 1'b1, 3'd2));
    tbl.push_back(mk(1'b1, 32'hB2, 1'b0, 1'b1, 1'b1, 3'd2));
    tbl.push_back(mk(1'b1, 32'hB3, 1'b0, 1'b1, 1'b1, 3'd3));
    tbl.push_back(mk(1'b1, 32'hB4, 1'b0, 1'b1, 1'b1, 3'd4));
    tbl.push_back(mk(1'b1, 32'hB5, 1'b0, 1'b0, 1'b1, 3'd5));
    tbl.push_back(mk(1'b0, '0,     1'b1, 1'b1, 1'b1, 3'd5));
    tbl.push_back(mk(1'b0, '0,     1'b1, 1'b1, 1'b1, 3'd4));
    tbl.push_back(mk(1'b0, '0,     1'b1, 1'b1, 1'b1, 3'd3));
    tbl.push_back(mk(1'b0, '0,     1'b1, 1'b1, 1'b1, 3'd2));
    tbl.push_back(mk(1'b0, '0,     1'b1, 1'b1, 1'b1, 3'd1));
    tbl.push_back(mk(1'b0, '0,     1'b1, 1'b1, 1'b0, 3'd0));

    rst = 1'b1;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0; s_hold = 1'b0; s_flush = '0;
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    chk("reset_occ", occupancy, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_drop", drop_count, 0);

    foreach (tbl[r]) begin
      drive(tbl[r].iv, tbl[r].d, tbl[r].ordy, 1'b0, '0);
      chk($sformatf("tbl%0d_in_ready", r), in_ready, tbl[r].ir);
      chk($sformatf("tbl%0d_out_valid", r), out_valid, tbl[r].ov);
      chk($sformatf("tbl%0d_occ", r), occupancy, tbl[r].occ);
      tick();
    end
    chk("tbl_sb_empty", sb.size(), 0);

    // hold for 3 cycles mid-stream
    for (int k = 0; k < 5; k++) begin drive(1'b1, 32'hC0 + k, 1'b1, 1'b0, '0); tick(); end
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    chk("prehold_out_valid", out_valid, 1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'hC5, 1'b1, 1'b1, '0);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 0);
      chk("hold_occ", occupancy, 5);
      tick();
    end
    drive(1'b1, 32'hC5, 1'b1, 1'b0, '0); tick();
    drive(1'b1, 32'hC6, 1'b1, 1'b0, '0); tick();
    drain("hold");

    // selective flush of stages 0 and 1 on a full stalled chain
    for (int k = 0; k < 5; k++) begin drive(1'b1, 32'hA0 + k, 1'b0, 1'b0, '0); tick(); end
    drive(1'b0, '0, 1'b0, 1'b0, 5'b00011);
    chk("flush_pre_occ", occupancy, 5);
    tick();
    void'(sb.pop_back());
    void'(sb.pop_back());
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    chk("flush_occ", occupancy, 3);
    chk("flush_drop", drop_count, 2);
    drain("flush");

    // flush of stage 0 with simultaneous input and output transfers
    for (int k = 0; k < 5; k++) begin drive(1'b1, 32'hD0 + k, 1'b1, 1'b0, '0); tick(); end
    drive(1'b1, 32'hD5, 1'b1, 1'b0, 5'b00001);
    chk("flush_xfer_out_valid", out_valid, 1);
    chk("flush_xfer_in_ready", in_ready, 1);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    chk("flush_xfer_drop", drop_count, 3);
    drive(1'b1, 32'hD6, 1'b1, 1'b0, '0); tick();
    drain("flush_xfer");

    // reset mid-stream while held
    for (int k = 0; k < 4; k++) begin drive(1'b1, 32'hE0 + k, 1'b0, 1'b0, '0); tick(); end
    drive(1'b1, 32'hEE, 1'b0, 1'b1, '0);
    chk("prerst_occ", occupancy, 4);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    chk("rst_occ", occupancy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_drop", drop_count, 0);
    drive(1'b1, 32'hF0, 1'b1, 1'b0, '0);
    tick();
    cnt = 0;
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    while (!out_valid && cnt < 10) begin
      tick();
      drive(1'b0, '0, 1'b1, 1'b0, '0);
      cnt++;
    end
    chk("rst_latency", cnt, D - 1);
    drain("rst");

    // drop counter saturation with CNT_W=2
    for (int k = 0; k < 5; k++) begin
      s_in_valid = 1'b1; s_in_data = 32'h10 + k;
      @(posedge clk);
      @(negedge clk);
    end
    s_in_valid = 1'b0;
    #1;
    chk("sat_occ_full", s_occ, 5);
    chk("sat_in_ready", s_in_ready, 0);
    chk("sat_out_valid", s_out_valid, 1);
    chk("sat_out_data", s_out_data, 32'h10);
    s_flush = '1;
    @(posedge clk);
    @(negedge clk);
    s_flush = '0;
    #1;
    chk("sat_drop", s_drop, 3);
    chk("sat_occ_empty", s_occ, 0);
    s_in_valid = 1'b1; s_in_data = 32'h20;
    @(posedge clk);
    @(negedge clk);
    s_in_valid = 1'b0; s_flush = '1;
    @(posedge clk);
    @(negedge clk);
    s_flush = '0;
    #1;
    chk("sat_drop_stays", s_drop, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
